jk_mode_counter: RTL and testbench

- Parametrised WIDTH-bit register bank built from JK flip-flop cells, with a per-cycle mode select.
- Bank runs either as independent raw JK flip-flops (per-bit J/K vectors) or as a modulo up/down counter.
- In counter mode the J/K inputs are generated internally as toggle terms.
- Generalises the single-bit JK flip-flop block to N bits, adds counting modes, a terminal-count flag and a wrap counter.

---
 rtl/jk_pkg.sv | 28 ++
 rtl/jk_cell.sv | 21 ++
 rtl/jk_mode_counter.sv | 113 +++++++++++
 tb/tb_jk_mode_counter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared mode and JK-encoding constants for the JK-cell counter bank.
package jk_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_UP   = 2'b01;
    localparam mode_t MODE_DOWN = 2'b10;
    localparam mode_t MODE_JK   = 2'b11;

    // Encoded as {j, k}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_TOG  = 2'b11;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            JK_SET:  r = 1'b1;
            JK_CLR:  r = 1'b0;
            JK_TOG:  r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with clock enable and synchronous active-high reset.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (ce) begin
            q <= jk_next(q, j, k);
        end
    end

endmodule

// File: rtl/jk_mode_counter.sv
// WIDTH-bit bank of JK cells run as raw flip-flops or as a modulo up/down counter.
// Define JK_MODE_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module jk_mode_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MOD_MAX = 2 ** WIDTH - 1,
    parameter int unsigned WRAP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  j,
    input  logic [WIDTH-1:0]  k,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qn,
    output logic              tc,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD_MAX);

    logic [WIDTH-1:0]  jv, kv;
    logic [WIDTH-1:0]  t_up, t_dn;
    logic              hit;
    logic              tc_q;
    logic [WRAP_W-1:0] wrap_q;

    // Toggle terms from a mask of the lower bits, avoiding a combinational chain.
    always_comb begin
        logic [WIDTH-1:0] lo;
        t_up = '0;
        t_dn = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lo      = (WIDTH'(1) << i) - WIDTH'(1);
            t_up[i] = &(q | ~lo);
            t_dn[i] = &(~q | ~lo);
        end
    end

    always_comb begin
        jv  = '0;
        kv  = '0;
        hit = 1'b0;
        unique case (mode)
            MODE_HOLD: begin
            end
            MODE_UP: begin
                if (q > MAX_Q) begin
                    kv = '1;
                end else if (q == MAX_Q) begin
                    hit = 1'b1;
`ifndef JK_MODE_COUNTER_SAT_EN
                    kv  = '1;
`endif
                end else begin
                    jv = t_up;
                    kv = t_up;
                end
            end
            MODE_DOWN: begin
                if (q > MAX_Q) begin
                    jv = MAX_Q;
                    kv = ~MAX_Q;
                end else if (q == '0) begin
                    hit = 1'b1;
`ifndef JK_MODE_COUNTER_SAT_EN
                    jv  = MAX_Q;
                    kv  = ~MAX_Q;
`endif
                end else begin
                    jv = t_dn;
                    kv = t_dn;
                end
            end
            MODE_JK: begin
                jv = j;
                kv = k;
            end
            default: begin
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .ce  (en),
            .j   (jv[i]),
            .k   (kv[i]),
            .q   (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q   <= 1'b0;
            wrap_q <= '0;
        end else begin
            tc_q <= en & hit;
            if (en && hit) begin
                wrap_q <= wrap_q + 1'b1;
            end
        end
    end

    assign qn       = ~q;
    assign tc       = tc_q;
    assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_jk_mode_counter.sv
// Directed bench for jk_mode_counter (WIDTH=4, MOD_MAX=9) with an arithmetic reference model.
module tb_jk_mode_counter;

    localparam int MAXV = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] j = '0;
    logic [3:0] k = '0;
    logic [3:0] q, qn;
    logic       tc;
    logic [7:0] wrap_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    int m_q = 0;
    int m_tc = 0;
    int m_wrap = 0;

    jk_mode_counter #(
        .WIDTH   (4),
        .MOD_MAX (MAXV),
        .WRAP_W  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .j        (j),
        .k        (k),
        .q        (q),
        .qn       (qn),
        .tc       (tc),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_q", int'(q), m_q);
            chk("model_qn", int'(qn), 15 - m_q);
            chk("model_tc", int'(tc), m_tc);
            chk("model_wrap", int'(wrap_cnt), m_wrap);
        end
    end

    // Apply one cycle of inputs and advance the model by the behavioural rules.
    task automatic step(input bit r, input bit e, input logic [1:0] md,
                        input logic [3:0] jj, input logic [3:0] kk);
        int nq, ntc, nw;
        @(negedge clk);
        rst = r; en = e; mode = md; j = jj; k = kk;
        nq = m_q; ntc = 0; nw = m_wrap;
        if (r) begin
            nq = 0; nw = 0;
        end else if (e) begin
            case (md)
                2'b01: begin
                    if (m_q > MAXV) nq = 0;
                    else if (m_q == MAXV) begin
`ifdef JK_MODE_COUNTER_SAT_EN
                        nq = MAXV;
`else
                        nq = 0;
`endif
                        ntc = 1; nw = (m_wrap + 1) % 256;
                    end else nq = m_q + 1;
                end
                2'b10: begin
                    if (m_q > MAXV) nq = MAXV;
                    else if (m_q == 0) begin
`ifdef JK_MODE_COUNTER_SAT_EN
                        nq = 0;
`else
                        nq = MAXV;
`endif
                        ntc = 1; nw = (m_wrap + 1) % 256;
                    end else nq = m_q - 1;
                end
                2'b11: nq = int'((jj & ~4'(m_q)) | (~kk & 4'(m_q)));
                default: nq = m_q;
            endcase
        end
        @(posedge clk);
        m_q = nq; m_tc = ntc; m_wrap = nw;
        if (r) chk_on = 1'b1;
        #1;
    endtask

    initial begin
        int up_q[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int dn_q[4]  = '{1, 0, 9, 8};

        // Reset
        step(1, 1, 2'b01, 4'h0, 4'h0);
        step(1, 1, 2'b01, 4'h0, 4'h0);
        chk("rst_q", int'(q), 0);
        chk("rst_qn", int'(qn), 15);
        chk("rst_tc", int'(tc), 0);
        chk("rst_wrap", int'(wrap_cnt), 0);

        // Up-wrap
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 2'b01, 4'h0, 4'h0);
            chk("up_q", int'(q), up_q[i]);
            chk("up_tc", int'(tc), (i == 9) ? 1 : 0);
        end
        chk("up_wrap", int'(wrap_cnt), 1);

        // Down-wrap from 2
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 2'b10, 4'h0, 4'h0);
            chk("dn_q", int'(q), dn_q[i]);
            chk("dn_tc", int'(tc), (i == 2) ? 1 : 0);
        end
        chk("dn_wrap", int'(wrap_cnt), 2);

        // Raw JK: 8 -> 1010, then j=0011 k=0101 -> 1011
        step(0, 1, 2'b11, 4'b0010, 4'b0000);
        chk("jk_load", int'(q), 10);
        step(0, 1, 2'b11, 4'b0011, 4'b0101);
        chk("jk_mix", int'(q), 11);
        chk("jk_tc", int'(tc), 0);

        // Disabled cycles freeze everything, even with a counting mode selected
        for (int i = 0; i < 3; i++) step(0, 0, 2'b01, 4'hF, 4'hF);
        chk("hold_q", int'(q), 11);
        chk("hold_wrap", int'(wrap_cnt), 2);

        // Out-of-range: 12 then UP -> 0 without tc
        step(0, 1, 2'b11, 4'b1100, 4'b0011);
        chk("oor_load", int'(q), 12);
        step(0, 1, 2'b01, 4'h0, 4'h0);
        chk("oor_up_q", int'(q), 0);
        chk("oor_up_tc", int'(tc), 0);

        // Out-of-range: 12 then DOWN -> MOD_MAX without tc
        step(0, 1, 2'b11, 4'b1100, 4'b0011);
        step(0, 1, 2'b10, 4'h0, 4'h0);
        chk("oor_dn_q", int'(q), 9);
        chk("oor_dn_tc", int'(tc), 0);
        chk("oor_wrap", int'(wrap_cnt), 2);

        // HOLD mode
        step(0, 1, 2'b00, 4'hF, 4'hF);
        chk("mhold_q", int'(q), 9);

        // Reset on what would be a wrapping edge
        step(1, 1, 2'b01, 4'h0, 4'h0);
        chk("rst_mid_q", int'(q), 0);
        chk("rst_mid_tc", int'(tc), 0);
        chk("rst_mid_wrap", int'(wrap_cnt), 0);

        step(0, 1, 2'b01, 4'h0, 4'h0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
